// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 32-point radix-2 SDF FFT: sample intake, flush, stage decode, sorter strobes.
// Optional DRAIN watchdog is compiled in with `define FFT_WDOG_EN.
module fft_frame_ctrl #(
    parameter int N_LOG2   = 5,
    parameter int SDF_LAT  = 31,
    parameter int CNT_W    = $clog2(SDF_LAT + (1 << N_LOG2)),
    parameter int WDOG_CYC = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             dp_en,
    output logic                             dp_zero,
    output logic [N_LOG2-1:0]                stage_bfly,
    output logic [N_LOG2*(N_LOG2-1)-1:0]     tw_addr,
    output logic                             sort_wr,
    output logic [N_LOG2-1:0]                sort_idx,
    input  logic                             sort_done,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             wdog_err
);

    localparam int N    = 1 << N_LOG2;
    localparam int TW_W = N_LOG2 - 1;

    localparam logic [CNT_W-1:0] T_LOAD_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] T_FIRST_OUT = CNT_W'(SDF_LAT);
    localparam logic [CNT_W-1:0] T_LAST      = CNT_W'(SDF_LAT + N - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    if (SDF_LAT < N - 1) begin : g_lat_chk
        $error("fft_frame_ctrl: SDF_LAT must be >= N-1");
    end
    if (WDOG_CYC < 2) begin : g_wdog_chk
        $error("fft_frame_ctrl: WDOG_CYC must be >= 2");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             wdog_fire;

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    t_d     = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    t_d = t_q + CNT_W'(1);
                    if (t_q == T_LOAD_LAST) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                t_d = t_q + CNT_W'(1);
                if (t_q == T_LAST) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                end
            end
            S_DRAIN: begin
                if (sort_done || wdog_fire) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef FFT_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC);
    localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYC - 1);

    logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic            wdog_err_q, wdog_err_d;

    // Counter is zero on the first DRAIN cycle because it is cleared in every other state.
    always_comb begin
        wdog_cnt_d = (state_q == S_DRAIN) ? wdog_cnt_q + WD_W'(1) : '0;
        wdog_fire  = (state_q == S_DRAIN) && !sort_done && (wdog_cnt_q == WDOG_LAST);
        wdog_err_d = wdog_err_q | wdog_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign in_ready   = (state_q == S_LOAD);
    assign dp_zero    = (state_q == S_FLUSH);
    assign dp_en      = (in_ready & in_valid) | dp_zero;

    // Stage decode follows t only on enabled cycles, so a stalled LOAD shows all zeros.
    always_comb begin
        stage_bfly = '0;
        tw_addr    = '0;
        sort_wr    = 1'b0;
        sort_idx   = '0;
        if (dp_en) begin
            for (int s = 0; s < N_LOG2; s++) begin
                stage_bfly[s]              = t_q[N_LOG2-1-s];
                tw_addr[s*TW_W +: TW_W]    = t_q[TW_W-1:0] << s;
            end
            sort_wr = (t_q >= T_FIRST_OUT) && (t_q <= T_LAST);
            if (sort_wr) begin
                sort_idx = N_LOG2'(t_q - T_FIRST_OUT);
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized self-checking bench for fft_frame_ctrl against a per-cycle frame model.
// Watchdog scenarios run only when FFT_WDOG_EN is defined.
module tb_fft_frame_ctrl;

    localparam int N_LOG2   = 5;
    localparam int N        = 32;
    localparam int SDF_LAT  = 31;
    localparam int TW_W     = 4;
    localparam int WDOG_CYC = 64;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, sort_done;
    logic        in_ready, dp_en, dp_zero, sort_wr, busy, frame_done, wdog_err;
    logic [4:0]  stage_bfly, sort_idx;
    logic [19:0] tw_addr;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_wdog = 1'b0;
    int got_idx[$];

    always #5 clk = ~clk;

    fft_frame_ctrl #(
        .N_LOG2(N_LOG2), .SDF_LAT(SDF_LAT), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .dp_en(dp_en), .dp_zero(dp_zero),
        .stage_bfly(stage_bfly), .tw_addr(tw_addr), .sort_wr(sort_wr),
        .sort_idx(sort_idx), .sort_done(sort_done), .busy(busy),
        .frame_done(frame_done), .wdog_err(wdog_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // k = number of datapath-enabled cycles before this one in the frame
    function automatic logic [4:0] exp_bfly(input int k);
        logic [4:0] r;
        for (int s = 0; s < N_LOG2; s++) r[s] = ((k >> (N_LOG2 - 1 - s)) % 2) != 0;
        return r;
    endfunction

    function automatic logic [19:0] exp_tw(input int k);
        logic [19:0] r;
        r = '0;
        for (int s = 0; s < N_LOG2; s++)
            r[s*TW_W +: TW_W] = TW_W'((k % (1 << (N_LOG2 - 1 - s))) * (1 << s));
        return r;
    endfunction

    task automatic check_cycle(input string ph, input bit e_rdy, input bit e_en,
                               input bit e_zero, input int k);
        bit         e_wr;
        logic [4:0] e_idx;
        e_wr  = e_en && (k >= SDF_LAT) && (k <= SDF_LAT + N - 1);
        e_idx = e_wr ? 5'(k - SDF_LAT) : 5'd0;
        chk({ph, "_in_ready"}, in_ready, e_rdy);
        chk({ph, "_dp_en"}, dp_en, e_en);
        chk({ph, "_dp_zero"}, dp_zero, e_zero);
        chk({ph, "_bfly"}, stage_bfly, e_en ? exp_bfly(k) : 5'd0);
        chk({ph, "_tw"}, tw_addr, e_en ? exp_tw(k) : 20'd0);
        chk({ph, "_sort_wr"}, sort_wr, e_wr);
        chk({ph, "_sort_idx"}, sort_idx, e_idx);
        chk({ph, "_busy"}, busy, 1'b1);
        chk({ph, "_frame_done"}, frame_done, 1'b0);
        chk({ph, "_wdog"}, wdog_err, exp_wdog);
        if (e_en && k == 21) begin
            chk("dec21_bfly", stage_bfly, 5'b10101);
            chk("dec21_tw", tw_addr, {4'd0, 4'd8, 4'd4, 4'd10, 4'd5});
        end
        if (sort_wr === 1'b1) got_idx.push_back(int'(sort_idx));
    endtask

    task automatic check_idle(input string ph, input bit e_fd);
        chk({ph, "_in_ready"}, in_ready, 1'b0);
        chk({ph, "_dp_en"}, dp_en, 1'b0);
        chk({ph, "_dp_zero"}, dp_zero, 1'b0);
        chk({ph, "_bfly"}, stage_bfly, 5'd0);
        chk({ph, "_tw"}, tw_addr, 20'd0);
        chk({ph, "_sort_wr"}, sort_wr, 1'b0);
        chk({ph, "_sort_idx"}, sort_idx, 5'd0);
        chk({ph, "_busy"}, busy, 1'b0);
        chk({ph, "_frame_done"}, frame_done, e_fd);
        chk({ph, "_wdog"}, wdog_err, exp_wdog);
    endtask

    task automatic check_drain();
        chk("drain_in_ready", in_ready, 1'b0);
        chk("drain_dp_en", dp_en, 1'b0);
        chk("drain_sort_wr", sort_wr, 1'b0);
        chk("drain_busy", busy, 1'b1);
        chk("drain_frame_done", frame_done, 1'b0);
        chk("drain_wdog", wdog_err, exp_wdog);
    endtask

    // Entered and left at posedge+1 with the DUT idle. done_delay < 0 means no sort_done.
    task automatic run_frame(input int stall_at, input int stall_len, input bit rand_gaps,
                             input int done_delay, input int start_j, input int abort_j);
        int k, cyc, stalled;
        bit v;
        got_idx.delete();
        start = 1'b1; in_valid = 1'b1; sort_done = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1'b0);
        chk("idle_dp_en", dp_en, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", busy, 1'b1);

        k = 0; cyc = 0; stalled = 0;
        while (k < N && cyc < 400) begin
            v = 1'b1;
            if (k == stall_at && stalled < stall_len) begin
                v = 1'b0; stalled++;
            end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
                v = 1'b0;
            end
            in_valid = v;
            #1;
            check_cycle("load", 1'b1, v, 1'b0, k);
            @(posedge clk); #1;
            if (v) k++;
            cyc++;
        end
        chk("load_accepts", k, N);
        if (!rand_gaps) chk("load_cycles", cyc, N + stalled);

        for (int j = 0; j < SDF_LAT; j++) begin
            in_valid  = 1'($urandom_range(0, 1));
            start     = (j == start_j);
            sort_done = (j == start_j);
            if (j == abort_j) rst = 1'b1;
            #1;
            check_cycle("flush", 1'b0, 1'b1, 1'b1, N + j);
            @(posedge clk); #1;
            start = 1'b0; sort_done = 1'b0;
            if (j == abort_j) begin
                rst = 1'b0; in_valid = 1'b0; exp_wdog = 1'b0;
                check_idle("abort", 1'b0);
                return;
            end
        end

        chk("strobe_count", got_idx.size(), N);
        for (int i = 0; i < got_idx.size() && i < N; i++) chk("strobe_idx", got_idx[i], i);

        if (done_delay >= 0) begin
            for (int d = 0; d < done_delay; d++) begin
                in_valid = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
                #1; check_drain();
                @(posedge clk); #1;
            end
            sort_done = 1'b1; start = 1'($urandom_range(0, 1));
            #1; check_drain();
            @(posedge clk); #1;
            sort_done = 1'b0;
        end else begin
            for (int d = 0; d < WDOG_CYC; d++) begin
                #1; check_drain();
                @(posedge clk); #1;
            end
            exp_wdog = 1'b1;
        end
        start = 1'b0; in_valid = 1'b0;
        check_idle("done", 1'b1);
        @(posedge clk); #1;
        check_idle("after_done", 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; sort_done = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_idle("reset", 1'b0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; sort_done = 1'b0;
        @(posedge clk); #1;
        check_idle("post_reset", 1'b0);

        run_frame(-1, 0, 1'b0, 5, -1, -1);
        run_frame(10, 3, 1'b0, $urandom_range(0, 20), -1, -1);
        run_frame(-1, 0, 1'b0, 2, 5, -1);
        run_frame(-1, 0, 1'b0, 0, -1, 8);
        run_frame(-1, 0, 1'b0, 3, -1, -1);
        repeat (4)
            run_frame($urandom_range(0, 31), $urandom_range(0, 4), 1'b1,
                      $urandom_range(0, 20), -1, -1);
`ifdef FFT_WDOG_EN
        run_frame(-1, 0, 1'b0, -1, -1, -1);
        run_frame(-1, 0, 1'b1, 4, -1, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exp_wdog = 1'b0;
        check_idle("wdog_clear", 1'b0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
